// File: rtl/demux_1xn_reg.sv
// demux_1xn_reg: registered 1-to-NCH demultiplexer with valid/ready handshakes.
// Optional dropped-word counter on drop_cnt when DEMUX_DROP_CNT_EN is defined.
module demux_1xn_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [SELW-1:0]      cur_ch
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

    logic [NCH-1:0][WIDTH-1:0] r_data;
    logic [NCH-1:0]            r_valid;
    logic [SELW-1:0]           r_ptr;
    logic [SELW-1:0]           w_tgt;
    logic [NCH-1:0]            w_hit;
    logic [NCH-1:0]            w_fill;
    logic                      w_accept;

    assign w_tgt = mode ? r_ptr : sel;

    // One-hot target decode; an out-of-range target hits no channel.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NCH; k++) begin
            w_hit[k] = ({1'b0, w_tgt} == k[SELW:0]);
        end
    end

    // Blocked only when the target holds a word its consumer is not taking.
    assign in_ready  = ~|(w_hit & r_valid & ~out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_fill    = w_hit & {NCH{w_accept}};

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign cur_ch    = r_ptr;

    // Valid flags: drain on out_ready, refill wins over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~out_ready) | w_fill;
        end
    end

    // Data registers only load on a fill, so stalled words stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_fill[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    // Round-robin pointer steps on accepted words in mode 1 only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept && mode) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

    logic       w_oor;
    logic [7:0] r_drop;

    assign w_oor    = ({1'b0, w_tgt} >= NCH_W);
    assign drop_cnt = r_drop;

    // Saturating count of discarded out-of-range words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (in_valid && w_oor && r_drop != 8'hFF) begin
            r_drop <= r_drop + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1xn_reg.sv
// tb_demux_1xn_reg: scoreboard bench for demux_1xn_reg.
// Main instance NCH=4, second instance NCH=3 for out-of-range handling.
module tb_demux_1xn_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [1:0]  cur_ch;

    logic [7:0]  in_data3 = '0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [1:0]  sel3 = '0;
    logic        mode3 = 1'b0;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3 = '0;
    logic [1:0]  cur_ch3;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
    logic [7:0]  drop_cnt3;
`endif

    int cmps = 0;
    int errs = 0;

    logic [7:0] exp_q [4][$];
    int         m_ptr = 0;

    always #5 clk = ~clk;

    demux_1xn_reg #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cur_ch(cur_ch)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    demux_1xn_reg #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .mode(mode3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .cur_ch(cur_ch3)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt3)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queue of words the DUT should be holding.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 4; k++) exp_q[k].delete();
                m_ptr = 0;
            end else begin
                int   t;
                logic rdy;
                logic [3:0] ev;
                ev = '0;
                for (int k = 0; k < 4; k++) ev[k] = (exp_q[k].size() != 0);
                chk("out_valid", out_valid, ev);
                for (int k = 0; k < 4; k++) begin
                    if (ev[k]) chk("out_data", out_data[k*8 +: 8], exp_q[k][0]);
                end
                chk("cur_ch", cur_ch, m_ptr);
                t   = mode ? m_ptr : int'(sel);
                rdy = (exp_q[t].size() == 0) || out_ready[t];
                chk("in_ready", in_ready, rdy);
                for (int k = 0; k < 4; k++) begin
                    if (ev[k] && out_ready[k]) void'(exp_q[k].pop_front());
                end
                if (in_valid && rdy) begin
                    exp_q[t].push_back(in_data);
                    if (mode) m_ptr = (m_ptr + 1) % 4;
                end
            end
        end
    endtask

    // Hold a word until accepted, then confirm it landed on channel ch.
    task automatic send(input logic [7:0] d, input logic [1:0] s,
                        input logic m, input int ch);
        int n;
        n = 0;
        in_data  = d;
        sel      = s;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            cmps++;
            errs++;
            $display("FAIL send_timeout: word %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("land_valid", out_valid[ch], 1'b1);
        chk("land_data", out_data[ch*8 +: 8], d);
    endtask

    // Two reset edges, then check the cleared state of both instances.
    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 4'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_cur_ch", cur_ch, 2'd0);
        chk("rst_valid3", out_valid3, 3'b0);
`ifdef DEMUX_DROP_CNT_EN
        chk("rst_drop", drop_cnt, 8'd0);
        chk("rst_drop3", drop_cnt3, 8'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        pulse_reset();

        // Addressed mode, all consumers ready.
        out_ready = 4'hF;
        send(8'hA1, 2'd0, 1'b0, 0);
        send(8'hB2, 2'd1, 1'b0, 1);
        send(8'hC3, 2'd2, 1'b0, 2);
        send(8'hD4, 2'd3, 1'b0, 3);

        // Back-pressure on channel 2.
        out_ready = 4'b1011;
        send(8'h77, 2'd2, 1'b0, 2);
        in_data  = 8'h88;
        sel      = 2'd2;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 4'hF;
        @(negedge clk);
        chk("bp_release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_valid", out_valid[2], 1'b1);
        chk("bp_data", out_data[23:16], 8'h88);

        // Round-robin from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h10 + i), 2'd0, 1'b1, i % 4);
        end
        chk("rr_cur_ch", cur_ch, 2'd2);
        out_ready = 4'b1011;
        send(8'h20, 2'd2, 1'b0, 2);
        in_data  = 8'h21;
        mode     = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rr_stall", in_ready, 1'b0);
            chk("rr_freeze", cur_ch, 2'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 4'hF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rr_resume", cur_ch, 2'd3);

        // Mode switch keeps the pointer.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h30 + i), 2'd0, 1'b1, i);
        end
        chk("ms_cur_ch", cur_ch, 2'd3);
        send(8'h55, 2'd1, 1'b0, 1);
        chk("ms_hold", cur_ch, 2'd3);

        // Out-of-range target on the three-channel instance.
        out_ready3 = 3'b000;
        in_data3   = 8'hEE;
        sel3       = 2'd3;
        in_valid3  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("drop_ready", in_ready3, 1'b1);
            chk("drop_valid", out_valid3, 3'b000);
            @(posedge clk);
            #1;
        end
`ifdef DEMUX_DROP_CNT_EN
        chk("drop_sat", drop_cnt3, 8'd255);
`endif
        in_data3 = 8'h5A;
        sel3     = 2'd2;
        @(negedge clk);
        chk("d3_ready", in_ready3, 1'b1);
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        chk("d3_valid", out_valid3, 3'b100);
        chk("d3_data", out_data3[23:16], 8'h5A);

        // Randomized traffic with a reset mid-stream.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) pulse_reset();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            sel       = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            out_ready = 4'($urandom) | 4'($urandom);
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        chk("end_empty", out_valid, 4'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/demux_1xn_reg.md
# demux_1xn_reg

Registered, parametrised 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel. It steers each accepted input word to one of NCH output registers, chosen either by an explicit select or by an internal round-robin pointer. It sits between a single producer and NCH independent consumers, and replaces the fixed-width combinational 1x4 demultiplexer wherever back-pressure or registered outputs are needed.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥1)
- NCH, 4, number of output channels (2..16)
- SELW, 2, select width; must be ≥ ceil(log2(NCH))

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  WIDTH  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts a word this cycle
- sel  in  SELW  target channel in addressed mode
- mode  in  1  0 = addressed (sel), 1 = round-robin (internal pointer)
- out_data  out  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  out  NCH  channel k holds a word
- out_ready  in  NCH  consumer k takes its word this cycle
- cur_ch  out  SELW  current round-robin pointer
- drop_cnt  out  8  dropped-word count (present only with DEMUX_DROP_CNT_EN)

## Operation
- Target channel t: sel when mode=0; pointer when mode=1.
- Each channel has a one-entry output register (data plus valid flag).
- Acceptance: a transfer occurs when in_valid && in_ready.
- in_ready = !out_valid[t] || out_ready[t], so the register accepts a new word in the same cycle its old word drains.
- On accept, out_data[t] <= in_data and out_valid[t] <= 1.
- Channel k ≠ t: out_valid[k] clears on out_ready[k]; its data holds until it is overwritten.
- Out-of-range target (t ≥ NCH, possible only in addressed mode):
  - in_ready = 1.
  - The word is discarded and no channel changes.
  - drop_cnt increments when the macro is compiled in.
- Round-robin pointer:
  - Advances by one only on an accepted word while mode=1.
  - Wraps from NCH-1 to 0.
  - Holds while mode=0, and holds on stall.
- Mode change: takes effect at the next cycle; the pointer keeps its value. No word is lost or duplicated.
- cur_ch always shows the pointer, including in mode 0.

## Timing
- Latency: 1 cycle. A word accepted at edge n appears with out_valid high after edge n.
- Throughput:
  - One word per cycle when consumers keep up.
  - The same channel is sustainable at one word per cycle with out_ready held high.
- in_ready is combinational from sel, mode, the pointer, out_valid and out_ready. It has no combinational path from in_valid.
- Outputs are held stable while out_valid[k]=1 and out_ready[k]=0 (AXI-style rule); data must not change under a stall.
- Reset values: out_valid=0, out_data=0, pointer/cur_ch=0, drop_cnt=0.
- Reset asserted mid-transfer: all held words are discarded at that edge. in_ready evaluates against the cleared state from the next cycle.
- Simultaneous drain and fill of the same channel: the new word wins and out_valid stays 1.

## Configuration
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - drop_cnt port and an 8-bit counter exist.
  - The counter increments on each discarded out-of-range word.
  - It saturates at 255 and clears only on rst.
- Undefined:
  - The port and counter are absent.
  - Out-of-range words are silently discarded with in_ready=1.

## Test plan
- Reset: assert rst 2 cycles mid-stream → after the edge, out_valid=0000, out_data=0, cur_ch=0, drop_cnt=0.
- Addressed mode, WIDTH=8, NCH=4, all out_ready=1: send 0xA1, 0xB2, 0xC3, 0xD4 with sel=0,1,2,3 → each channel shows its word with out_valid 1 cycle after acceptance; in_ready stays 1.
- Back-pressure: out_ready[2]=0, two words to sel=2 → first held on channel 2, second stalls with in_ready=0. Raise out_ready[2] → second word accepted that cycle and present next cycle.
- Round-robin: mode=1, 6 words 0x10..0x15 → channels 0,1,2,3,0,1. cur_ch ends at 2. A stall on channel 2 freezes the pointer at 2.
- Mode switch: after 3 round-robin words (cur_ch=3), set mode=0, sel=1, send 0x55 → channel 1 gets 0x55 and cur_ch stays 3.
- Drop (NCH=3, SELW=2, macro defined): 300 words with sel=3 → no out_valid change, in_ready=1 throughout, drop_cnt saturates at 255.
